// File: rtl/dsp_pkg.sv
// Shared constants and helpers for the DSP48A1 P-result path.
package dsp_pkg;

  localparam int DSP_P_WIDTH    = 48;
  localparam int DSP_P_LATENCY  = 4;
  localparam int DSP_FIFO_DEPTH = 8;

  // Ceiling log2, usable in parameter expressions; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/dsp_sync_fifo.sv
// Single-clock FIFO with an occupancy counter to tell full from empty.
// Head data reads as zero while empty so the stream output is clean after reset/flush.
module dsp_sync_fifo
  import dsp_pkg::*;
#(
  parameter int  WIDTH = DSP_P_WIDTH,
  parameter int  DEPTH = DSP_FIFO_DEPTH,
  localparam int CW    = clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, empty, do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_push = push & (~full | pop) & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  // Next-state for pointers and occupancy; flush wins over any traffic.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/dsp_result_drain.sv
// Receive side of the fixed-latency DSP48A1 datapath: issues credits, tracks
// in-flight ops through a valid shift register and lands every P result in a FIFO.
// Optional feature: define DRAIN_ERR_EN to add the sticky 'err' output.
module dsp_result_drain
  import dsp_pkg::*;
#(
  parameter int  WIDTH   = DSP_P_WIDTH,
  parameter int  LATENCY = DSP_P_LATENCY,
  parameter int  DEPTH   = DSP_FIFO_DEPTH,
  localparam int OCC_W   = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [WIDTH-1:0] res_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OCC_W-1:0] occupancy
`ifdef DRAIN_ERR_EN
  ,
  output logic             err
`endif
);

  localparam int IF_W  = clog2(LATENCY + 1);
  localparam int SUM_W = clog2(DEPTH + LATENCY + 1) + 1;

  logic [LATENCY-1:0] vld_sr_q, vld_sr_d;
  logic [IF_W-1:0]    inflight_q, inflight_d;
  logic [SUM_W-1:0]   credit_sum;
  logic               issue_fire, capture, pop;

  assign issue_fire = issue_valid & issue_ready;
  assign capture    = vld_sr_q[LATENCY-1];
  assign pop        = out_valid & out_ready;

  // Credits count stored plus in-flight results, so a capture can never meet a full FIFO.
  // Only registered state feeds this; a pop returns its credit one cycle later.
  assign credit_sum  = SUM_W'(occupancy) + SUM_W'(inflight_q);
  assign issue_ready = ~rst & (credit_sum < SUM_W'(DEPTH));

  // Valid tracking and in-flight count; flush drops everything issued so far.
  always_comb begin
    vld_sr_d   = (vld_sr_q << 1) | LATENCY'(issue_fire);
    inflight_d = inflight_q + IF_W'(issue_fire) - IF_W'(capture);
    if (flush) begin
      vld_sr_d   = '0;
      inflight_d = '0;
    end
  end

  // Tracking registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sr_q   <= '0;
      inflight_q <= '0;
    end else begin
      vld_sr_q   <= vld_sr_d;
      inflight_q <= inflight_d;
    end
  end

  dsp_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (capture),
    .pop   (pop),
    .wdata (res_in),
    .rdata (out_data),
    .count (occupancy)
  );

  assign out_valid = (occupancy != '0);

`ifdef DRAIN_ERR_EN
  logic err_q, err_d;

  // Sticky error: capture while full (result lost) or pop while empty.
  always_comb begin
    err_d = err_q;
    if (flush) err_d = 1'b0;
    else if ((capture && occupancy == OCC_W'(DEPTH)) || (pop && occupancy == '0)) err_d = 1'b1;
  end

  // Error flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_dsp_result_drain.sv
// Directed bench for dsp_result_drain (WIDTH 48, LATENCY 4, DEPTH 8).
// A small model of the DSP register pipeline feeds res_in with the operand of each fire.
module tb_dsp_result_drain;

  localparam int W   = 48;
  localparam int LAT = 4;
  localparam int DEP = 8;

  logic         clk = 1'b0;
  logic         rst, flush, issue_valid, issue_ready, out_valid, out_ready;
  logic [W-1:0] res_in, out_data, operand;
  logic [3:0]   occupancy;
`ifdef DRAIN_ERR_EN
  logic         err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dsp_result_drain #(.WIDTH(W), .LATENCY(LAT), .DEPTH(DEP)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .res_in      (res_in),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .occupancy   (occupancy)
`ifdef DRAIN_ERR_EN
    ,
    .err         (err)
`endif
  );

  // DSP pipeline model: operand enters on fire and appears on res_in LAT-1 edges later,
  // so the drain samples it on the LAT-th edge after the fire.
  logic [W-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= (issue_valid && issue_ready) ? operand : 48'h0BAD_0000_0000;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign res_in = pipe[LAT-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From empty with no pops: exactly DEPTH fires are accepted, then the FIFO fills.
  task automatic fill(input int base, input string tag);
    int fires = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 14; c++) begin
      issue_valid = 1'b1;
      operand     = W'(base + fires);
      if (issue_ready) fires++;
      tick();
    end
    issue_valid = 1'b0;
    chk({tag, "_fires"}, fires, 8);
    chk({tag, "_ready"}, issue_ready, 0);
    chk({tag, "_occ"}, occupancy, 8);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; issue_valid = 1'b0; out_ready = 1'b0; operand = '0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_issue_ready", issue_ready, 0);
`ifdef DRAIN_ERR_EN
    chk("rst_err", err, 0);
`endif
    rst = 1'b0;
    #1;
    chk("rel_issue_ready", issue_ready, 1);
    tick();

    // Single op: visible only after the 4th edge following the fire.
    issue_valid = 1'b1; operand = 48'h1234;
    tick();
    issue_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t1_early_valid", out_valid, 0);
      tick();
    end
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 48'h1234);
    chk("t1_occ", occupancy, 1);
    out_ready = 1'b1;
    tick();
    chk("t1_pop_valid", out_valid, 0);
    chk("t1_pop_occ", occupancy, 0);

    // Streaming: one result per cycle, values k-4 after edge k.
    for (int k = 1; k <= 20; k++) begin
      if (k <= 16) begin
        issue_valid = 1'b1;
        operand     = W'(k);
        chk("t2_ready", issue_ready, 1);
      end else begin
        issue_valid = 1'b0;
      end
      tick();
      if (k <= 4) chk("t2_fill_valid", out_valid, 0);
      else begin
        chk("t2_valid", out_valid, 1);
        chk("t2_data", out_data, 64'(k - 4));
        chk("t2_occ", occupancy, 1);
      end
    end
    tick();
    chk("t2_end_valid", out_valid, 0);
    out_ready = 1'b0;

    // Backpressure: 8 fires, full FIFO, credit returns one cycle after the first pop.
    fill(100, "t3");
    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      chk("t3_valid", out_valid, 1);
      chk("t3_data", out_data, 64'(100 + j));
      tick();
      if (j == 0) begin
        chk("t3_credit", issue_ready, 1);
        chk("t3_occ7", occupancy, 7);
      end
    end
    chk("t3_empty", out_valid, 0);
    out_ready = 1'b0;

    // Pop from full, then pop and fire together; nothing is lost.
    fill(200, "t4");
    out_ready = 1'b1; issue_valid = 1'b1; operand = 48'd300;
    tick();
    chk("t4_occ7", occupancy, 7);
    chk("t4_ready", issue_ready, 1);
    chk("t4_head201", out_data, 201);
    tick();
    chk("t4_occ6", occupancy, 6);
    chk("t4_head202", out_data, 202);
    out_ready = 1'b0; issue_valid = 1'b0;
    tick(); tick(); tick();
    chk("t4_occ6_hold", occupancy, 6);
    chk("t4_ready_hold", issue_ready, 1);
    tick();
    chk("t4_occ7_cap", occupancy, 7);
    out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      chk("t4_data", out_data, 64'(202 + j));
      tick();
    end
    chk("t4_last_valid", out_valid, 1);
    chk("t4_last", out_data, 300);
    tick();
    chk("t4_empty", out_valid, 0);
    out_ready = 1'b0;

    // Flush with 2 stored and 3 in flight.
    issue_valid = 1'b1; operand = 48'd400; tick();
    operand = 48'd401; tick();
    issue_valid = 1'b0;
    tick(); tick(); tick(); tick();
    chk("t5_occ2", occupancy, 2);
    issue_valid = 1'b1;
    operand = 48'd402; tick();
    operand = 48'd403; tick();
    operand = 48'd404; tick();
    chk("t5_occ2_pre", occupancy, 2);
    flush = 1'b1; operand = 48'd405;
    tick();
    flush = 1'b0; issue_valid = 1'b0;
    chk("t5_valid", out_valid, 0);
    chk("t5_occ", occupancy, 0);
    chk("t5_ready", issue_ready, 1);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t5_no_late", out_valid, 0);
    end

    // Asynchronous reset between edges while busy.
    issue_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      operand = W'(500 + k);
      tick();
    end
    chk("t6_occ2", occupancy, 2);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_valid", out_valid, 0);
    chk("t6_occ", occupancy, 0);
    chk("t6_data", out_data, 0);
    chk("t6_ready", issue_ready, 0);
    issue_valid = 1'b0;
    #2;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t6_no_late", out_valid, 0);
    end
    chk("t6_ready_back", issue_ready, 1);

`ifdef DRAIN_ERR_EN
    // Forced capture while full sets the sticky error; flush clears it.
    fill(600, "t7");
    chk("t7_err0", err, 0);
    force dut.vld_sr_q = 4'b1000;
    tick();
    release dut.vld_sr_q;
    chk("t7_err1", err, 1);
    chk("t7_occ", occupancy, 8);
    tick();
    chk("t7_sticky", err, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t7_clr", err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
